usb_tx_encoder: RTL and testbench
=================================

Name: usb_tx_encoder

Overview:
Full-speed USB serial transmitter, the transmit-side counterpart to the Rx front end's input synchronizer and decoder. It takes packet bytes from the protocol layer over a valid/ready byte handshake and drives D+/D- directly. It emits SYNC, then LSB-first data with NRZI encoding and bit stuffing, then EOP. It then returns the bus to idle J.

Parameters:
CLKS_PER_BIT, 8, clk cycles per USB bit period (must be >= 2)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
tx_start  input  1  one-cycle request to begin a packet; sampled only in IDLE
tx_data  input  8  next packet byte, transmitted LSB first
tx_valid  input  1  tx_data/tx_last hold a valid byte
tx_last  input  1  qualifies tx_data as final byte of packet
tx_ready  output  1  one-cycle pulse: byte on tx_data/tx_last consumed this cycle
d_plus  output  1  USB D+ line drive
d_minus  output  1  USB D- line drive
tx_busy  output  1  high from cycle after accepted tx_start until the cycle tx_done pulses
tx_done  output  1  one-cycle pulse when EOP/idle J bit completes
tx_error  output  1  one-cycle pulse on underrun (tx_valid low when a byte is required)

Behaviour:
- Reset (async, n_rst=0): d_plus=1, d_minus=0 (J), tx_busy=0, tx_ready=0, tx_done=0, tx_error=0, FSM=IDLE, ones_cnt=0, bit counters=0. Takes effect immediately, including mid-packet; no tx_done is issued for an aborted packet.
- All outputs are registered. The bit timer counts 0..CLKS_PER_BIT-1. Lines change only on the cycle the timer wraps to 0, i.e. at a bit boundary.
- States: IDLE -> SYNC -> DATA -> EOP_SE0 -> EOP_J -> IDLE.
- IDLE: lines J. tx_start=1 -> SYNC. The first SYNC bit appears on the lines in the cycle after tx_start is sampled. tx_start in any other state is ignored.
- SYNC: transmits bit pattern 0,0,0,0,0,0,0,1 (0x80 LSB first), one bit per CLKS_PER_BIT cycles.
- NRZI: data 0 -> invert line state (J<->K; K = d_plus 0, d_minus 1). Data 1 -> hold line state.
- Bit stuffing:
  - ones_cnt counts consecutive 1s, including SYNC's final 1, and clears on any 0.
  - When ones_cnt reaches 6, the next bit period transmits a stuffed 0 (a transition) that consumes no data bit; ones_cnt then clears.
  - A stuff bit owed after the last data bit is sent before EOP.
- Byte load:
  - In the final cycle of SYNC's last bit, and in the final cycle of each byte's last bit (after any stuff bit owed), the block samples tx_valid.
  - If tx_valid=1, it latches tx_data/tx_last, pulses tx_ready that same cycle, and enters or stays in DATA.
  - After a byte with tx_last=1 completes, no sample is taken; the FSM goes to EOP_SE0.
- Underrun: if tx_valid=0 at a required load, pulse tx_error and go to EOP_SE0. The packet is truncated.
- EOP_SE0: d_plus=0, d_minus=0 for 2 bit periods.
- EOP_J: J for 1 bit period. In its final cycle, tx_done pulses and tx_busy falls; the FSM returns to IDLE and ones_cnt clears.
- tx_valid and tx_start may both be high in IDLE. tx_valid is ignored until the first load point.
- tx_ready never pulses outside a load point, and never pulses with tx_valid=0.

Test Plan:
1. Reset, hold 20 cycles -> d_plus=1, d_minus=0, tx_busy=0, no pulses. Assert reset mid-DATA -> J in the same cycle, tx_busy=0, no tx_done.
2. tx_start; byte 0x00 with tx_last=1 valid throughout -> lines: 7 alternating K/J transitions, hold, then 8 toggles. Then SE0 for 16 cycles, J for 8. tx_ready pulses once at cycle 64. tx_done pulses at cycle 152.
3. Byte 0xFF, tx_last=1 -> after 5 data 1s, one stuffed transition, then 3 held bits. Data phase is 9 bit periods; tx_done at cycle 160.
4. Bytes 0xA5 then 0x3C (tx_last on the second) -> exactly two tx_ready pulses, at cycles 64 and 128. Decoded NRZI stream equals 0x80,0xA5,0x3C LSB first, with no stuffing.
5. tx_start with tx_valid=0 -> tx_error pulse at cycle 64, no tx_ready, SE0 immediately after SYNC, tx_done at cycle 88.
6. tx_start re-pulsed during DATA -> ignored. Packet bit count unchanged; exactly one tx_done.

Source files
------------

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: full-speed USB serial transmitter driving D+/D- directly.
// Sends SYNC, then NRZI-encoded, bit-stuffed packet bytes (LSB first), then EOP, then idles at J.
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_PRE  = TW'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP_SE0,
        S_EOP_J
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [2:0]      ones_q, ones_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            last_q, last_d;
    logic            eop_q, eop_d;
    logic            dp_q, dp_d;
    logic            dm_q, dm_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic            error_q, error_d;
    logic            done_q, done_d;

    logic at_pre, at_wrap, byte_done;
    logic send_en, send_bit, load_en, to_eop;

    // Pulses are registered one cycle early so they sit on the final cycle of a bit period.
    assign at_pre    = (timer_q == T_PRE);
    assign at_wrap   = (timer_q == T_LAST);
    assign byte_done = (bit_cnt_q == 4'd8) && (ones_q != 3'd6);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        shreg_d   = shreg_q;
        last_d    = last_q;
        eop_d     = eop_q;
        dp_d      = dp_q;
        dm_d      = dm_q;
        busy_d    = busy_q;
        ready_d   = 1'b0;
        error_d   = 1'b0;
        done_d    = 1'b0;
        send_en   = 1'b0;
        send_bit  = 1'b0;
        load_en   = 1'b0;
        to_eop    = 1'b0;

        if (state_q != S_IDLE && !at_wrap) timer_d = timer_q + TW'(1);

        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    state_d   = S_SYNC;
                    bit_cnt_d = 4'd0;
                    busy_d    = 1'b1;
                    eop_d     = 1'b0;
                    send_en   = 1'b1;
                end
            end
            S_SYNC: begin
                if (at_pre && bit_cnt_q == 4'd7) load_en = 1'b1;
                if (at_wrap) begin
                    if (bit_cnt_q != 4'd7) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        send_en   = 1'b1;
                        send_bit  = (bit_cnt_q == 4'd6);
                    end else if (eop_q) begin
                        to_eop = 1'b1;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = 4'd1;
                        send_en   = 1'b1;
                        send_bit  = shreg_q[0];
                    end
                end
            end
            S_DATA: begin
                if (at_pre && byte_done) begin
                    if (last_q) eop_d   = 1'b1;
                    else        load_en = 1'b1;
                end
                if (at_wrap) begin
                    if (ones_q == 3'd6) begin
                        // Stuffed zero: forces a transition, consumes no data bit.
                        send_en  = 1'b1;
                        send_bit = 1'b0;
                    end else if (bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        send_en   = 1'b1;
                        send_bit  = shreg_q[bit_cnt_q[2:0]];
                    end else if (eop_q) begin
                        to_eop = 1'b1;
                    end else begin
                        bit_cnt_d = 4'd1;
                        send_en   = 1'b1;
                        send_bit  = shreg_q[0];
                    end
                end
            end
            S_EOP_SE0: begin
                if (at_wrap) begin
                    if (bit_cnt_q == 4'd1) begin
                        state_d   = S_EOP_J;
                        bit_cnt_d = 4'd0;
                        dp_d      = 1'b1;
                        dm_d      = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_EOP_J: begin
                if (at_pre) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
                if (at_wrap) begin
                    state_d   = S_IDLE;
                    bit_cnt_d = 4'd0;
                    ones_d    = 3'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_en) begin
            if (tx_valid) begin
                shreg_d = tx_data;
                last_d  = tx_last;
                ready_d = 1'b1;
            end else begin
                error_d = 1'b1;
                eop_d   = 1'b1;
            end
        end

        // NRZI: a 0 toggles J<->K, a 1 holds the line.
        if (send_en) begin
            if (!send_bit) begin
                dp_d = ~dp_q;
                dm_d = ~dm_q;
            end
            ones_d = send_bit ? ones_q + 3'd1 : 3'd0;
        end

        if (to_eop) begin
            state_d   = S_EOP_SE0;
            bit_cnt_d = 4'd0;
            eop_d     = 1'b0;
            dp_d      = 1'b0;
            dm_d      = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= 4'd0;
            ones_q    <= 3'd0;
            shreg_q   <= 8'h00;
            last_q    <= 1'b0;
            eop_q     <= 1'b0;
            dp_q      <= 1'b1;
            dm_q      <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
            shreg_q   <= shreg_d;
            last_q    <= last_d;
            eop_q     <= eop_d;
            dp_q      <= dp_d;
            dm_q      <= dm_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            done_q    <= done_d;
        end
    end

    assign d_plus   = dp_q;
    assign d_minus  = dm_q;
    assign tx_busy  = busy_q;
    assign tx_ready = ready_q;
    assign tx_done  = done_q;
    assign tx_error = error_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Self-checking bench for usb_tx_encoder: per-cycle comparison against a bit-period line model,
// an NRZI/destuff decoder of the DUT lines, and literal event-cycle expectations.
module tb_usb_tx_encoder;

    localparam int CPB  = 8;
    localparam int MAXC = 2048;
    localparam int GAP  = 6;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       d_plus;
    logic       d_minus;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .d_plus   (d_plus),
        .d_minus  (d_minus),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_error (tx_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Packet bytes and expected per-cycle outputs {dp, dm, busy, ready, done, err}.
    logic [7:0] pkt [8];
    logic [5:0] exp_v [MAXC];
    int         exp_end;

    // Model state while building the expected waveform.
    int   m_per;
    int   m_ones;
    logic m_line_j;

    // Observations from the last packet.
    int          m_ready_cnt;
    int          m_ready_cyc [4];
    int          m_err_cyc;
    int          m_done_cyc;
    int          m_done_cnt;
    logic [31:0] dec_val;
    int          dec_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic put_sym(input logic [1:0] lv);
        for (int c = m_per * CPB + 1; c <= (m_per + 1) * CPB; c++) begin
            exp_v[c][5:4] = lv;
            exp_v[c][3]   = 1'b1;
        end
        m_per++;
    endtask

    task automatic model_bit(input logic b);
        if (!b) m_line_j = ~m_line_j;
        m_ones = b ? m_ones + 1 : 0;
        put_sym(m_line_j ? 2'b10 : 2'b01);
        if (m_ones == 6) begin
            m_line_j = ~m_line_j;
            m_ones   = 0;
            put_sym(m_line_j ? 2'b10 : 2'b01);
        end
    endtask

    // Builds the expected waveform: SYNC, bytes with stuffing, load points, EOP.
    task automatic build_model(input int nbytes, input bit underrun);
        for (int c = 0; c < MAXC; c++) exp_v[c] = 6'b10_0000;
        m_per    = 0;
        m_ones   = 0;
        m_line_j = 1'b1;
        for (int i = 0; i < 8; i++) model_bit(i == 7);
        for (int k = 0; k <= nbytes; k++) begin
            if (k == nbytes) begin
                if (underrun) exp_v[m_per * CPB][0] = 1'b1;
            end else begin
                exp_v[m_per * CPB][2] = 1'b1;
                for (int i = 0; i < 8; i++) model_bit(pkt[k][i]);
            end
        end
        put_sym(2'b00);
        put_sym(2'b00);
        put_sym(2'b10);
        exp_end = m_per * CPB;
        exp_v[exp_end][1] = 1'b1;
        exp_v[exp_end][3] = 1'b0;
    endtask

    task automatic drive_data(input int idx, input int nbytes, input bit underrun, input bit noisy);
        if (idx < nbytes) begin
            tx_valid = 1'b1;
            tx_data  = pkt[idx];
            tx_last  = !underrun && (idx == nbytes - 1);
        end else begin
            tx_valid = 1'b0;
            tx_data  = noisy ? 8'($urandom) : 8'h00;
            tx_last  = noisy ? 1'($urandom) : 1'b0;
        end
    endtask

    // Called at a negedge: starts a packet, then compares every cycle until a few cycles past done.
    task automatic run_packet(input int nbytes, input bit underrun, input bit noisy);
        int         idx;
        int         ones;
        logic       prev_j;
        logic       b;
        bit         in_eop;
        logic [5:0] act;
        build_model(nbytes, underrun);
        m_ready_cnt = 0;
        m_err_cyc   = -1;
        m_done_cyc  = -1;
        m_done_cnt  = 0;
        dec_val     = '0;
        dec_len     = 0;
        idx         = 0;
        ones        = 0;
        prev_j      = 1'b1;
        in_eop      = 1'b0;
        tx_start    = 1'b1;
        drive_data(idx, nbytes, underrun, noisy);
        for (int c = 1; c <= exp_end + GAP; c++) begin
            @(negedge clk);
            act = {d_plus, d_minus, tx_busy, tx_ready, tx_done, tx_error};
            check($sformatf("cycle %0d {dp,dm,busy,ready,done,err}", c), 32'(act), 32'(exp_v[c]));
            if (tx_ready) begin
                if (m_ready_cnt < 4) m_ready_cyc[m_ready_cnt] = c;
                m_ready_cnt++;
                idx++;
            end
            if (tx_error) m_err_cyc = c;
            if (tx_done) begin
                m_done_cyc = c;
                m_done_cnt++;
            end
            if (c % CPB == 0 && !in_eop) begin
                if (!d_plus && !d_minus) begin
                    in_eop = 1'b1;
                end else begin
                    b      = (d_plus == prev_j);
                    prev_j = d_plus;
                    if (ones == 6) begin
                        ones = 0;
                    end else begin
                        if (dec_len < 32) dec_val[dec_len] = b;
                        dec_len++;
                        ones = b ? ones + 1 : 0;
                    end
                end
            end
            tx_start = (noisy && c < exp_end - 1) ? ($urandom_range(0, 15) == 0) : 1'b0;
            if (c < exp_end) begin
                drive_data(idx, nbytes, underrun, noisy);
            end else begin
                tx_valid = 1'($urandom);
                tx_data  = 8'($urandom);
                tx_last  = 1'($urandom);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst    = 1'b0;
        tx_start = 1'b0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_data  = 8'h00;

        // Reset held: idle J, no pulses.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("reset hold outputs", 32'({d_plus, d_minus, tx_busy, tx_ready, tx_done, tx_error}),
                  32'(6'b10_0000));
        end
        n_rst = 1'b1;
        @(negedge clk);

        // Single 0x00 byte.
        pkt[0] = 8'h00;
        run_packet(1, 1'b0, 1'b0);
        check("model end 0x00", exp_end, 152);
        check("0x00 ready count", m_ready_cnt, 1);
        check("0x00 ready cycle", m_ready_cyc[0], 64);
        check("0x00 done cycle", m_done_cyc, 152);
        check("0x00 decoded bits", dec_val, 32'h0000_0080);
        check("0x00 decoded length", dec_len, 16);

        // Single 0xFF byte: one stuffed bit.
        pkt[0] = 8'hFF;
        run_packet(1, 1'b0, 1'b0);
        check("model end 0xFF", exp_end, 160);
        check("0xFF done cycle", m_done_cyc, 160);
        check("0xFF decoded bits", dec_val, 32'h0000_FF80);
        check("0xFF decoded length", dec_len, 16);

        // Two bytes.
        pkt[0] = 8'hA5;
        pkt[1] = 8'h3C;
        run_packet(2, 1'b0, 1'b0);
        check("A5/3C ready count", m_ready_cnt, 2);
        check("A5/3C ready 0 cycle", m_ready_cyc[0], 64);
        check("A5/3C ready 1 cycle", m_ready_cyc[1], 128);
        check("A5/3C decoded bits", dec_val, 32'h003C_A580);
        check("A5/3C decoded length", dec_len, 24);

        // Underrun at the first load point.
        run_packet(0, 1'b1, 1'b0);
        check("underrun error cycle", m_err_cyc, 64);
        check("underrun ready count", m_ready_cnt, 0);
        check("underrun done cycle", m_done_cyc, 88);

        // tx_start re-pulsed during the packet is ignored.
        pkt[0] = 8'h12;
        pkt[1] = 8'h34;
        run_packet(2, 1'b0, 1'b1);
        check("restart done count", m_done_cnt, 1);
        check("restart done cycle", m_done_cyc, 216);

        // Reset asserted mid-DATA: lines return to J at once, no tx_done.
        tx_start = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        tx_last  = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            tx_start = 1'b0;
        end
        check("pre-reset lines K", 32'({d_plus, d_minus}), 32'(2'b01));
        n_rst = 1'b0;
        #1;
        check("async reset lines J", 32'({d_plus, d_minus}), 32'(2'b10));
        check("async reset busy", 32'(tx_busy), 32'(0));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("mid-packet reset hold", 32'({d_plus, d_minus, tx_busy, tx_ready, tx_done, tx_error}),
                  32'(6'b10_0000));
        end
        n_rst    = 1'b1;
        tx_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("post-reset idle", 32'({d_plus, d_minus, tx_busy, tx_ready, tx_done, tx_error}),
                  32'(6'b10_0000));
        end

        // Randomized packets.
        for (int p = 0; p < 40; p++) begin
            int nb;
            bit ur;
            bit nz;
            ur = ($urandom_range(0, 3) == 0);
            nb = ur ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 4));
            nz = 1'($urandom);
            for (int k = 0; k < nb; k++) begin
                case ($urandom_range(0, 3))
                    0:       pkt[k] = 8'hFF;
                    1:       pkt[k] = 8'h7E;
                    default: pkt[k] = 8'($urandom);
                endcase
            end
            run_packet(nb, ur, nz);
            check($sformatf("random pkt %0d ready count", p), m_ready_cnt, nb);
            check($sformatf("random pkt %0d done count", p), m_done_cnt, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
